// File: rtl/usbf_csr_arb.sv
// Two-port round-robin arbiter and access sequencer in front of the USB device CSR port.
// One access is in flight at a time: grant, strobe, wait for completion or timeout, respond.
module usbf_csr_arb #(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 16
) (
  input  logic        hclk_i,
  input  logic        hrstn_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic        req0_write_i,
  input  logic [31:0] req0_addr_i,
  input  logic [31:0] req0_wdata_i,
  output logic        req0_done_o,
  output logic        req0_err_o,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic        req1_write_i,
  input  logic [31:0] req1_addr_i,
  input  logic [31:0] req1_wdata_i,
  output logic        req1_done_o,
  output logic        req1_err_o,
  output logic [31:0] rsp_rdata_o,
  output logic        wt_en_o,
  output logic        rd_en_o,
  output logic        enable_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  input  logic        wt_ready_i,
  input  logic        rd_ready_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } csr_req_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  state_t     state;
  logic       rr;
  logic       owner;
  logic       wr;
  logic [CNT_W-1:0] cnt;

  logic       gnt0, gnt1, match;
  csr_req_t   sel;

  // rr names the port that wins when both are valid
  always_comb begin
    gnt0  = req0_valid_i & (~req1_valid_i | ~rr);
    gnt1  = req1_valid_i & (~req0_valid_i |  rr);
    sel   = gnt1 ? '{req1_write_i, req1_addr_i, req1_wdata_i}
                 : '{req0_write_i, req0_addr_i, req0_wdata_i};
    match = wr ? wt_ready_i : rd_ready_i;
  end

  // Gated by reset so ready reads 0 while reset is asserted, even with valid held high.
  assign req0_ready_o = hrstn_i & (state == IDLE) & gnt0;
  assign req1_ready_o = hrstn_i & (state == IDLE) & gnt1;

  always_ff @(posedge hclk_i or negedge hrstn_i) begin
    if (!hrstn_i) begin
      state       <= IDLE;
      rr          <= 1'b0;
      owner       <= 1'b0;
      wr          <= 1'b0;
      cnt         <= '0;
      addr_o      <= '0;
      wdata_o     <= '0;
      rsp_rdata_o <= '0;
      wt_en_o     <= 1'b0;
      rd_en_o     <= 1'b0;
      enable_o    <= 1'b0;
      req0_done_o <= 1'b0;
      req1_done_o <= 1'b0;
      req0_err_o  <= 1'b0;
      req1_err_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt0 | gnt1) begin
          state    <= ISSUE;
          owner    <= gnt1;
          rr       <= gnt0;
          wr       <= sel.write;
          addr_o   <= sel.addr;
          wdata_o  <= sel.wdata;
          wt_en_o  <= sel.write;
          rd_en_o  <= ~sel.write;
          enable_o <= 1'b1;
        end
        ISSUE: begin
          wt_en_o <= 1'b0;
          rd_en_o <= 1'b0;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // A completion arriving on the last allowed cycle still counts as success.
          if (match || cnt == CNT_MAX) begin
            if (match && !wr) rsp_rdata_o <= rdata_i;
            state       <= RESP;
            enable_o    <= 1'b0;
            req0_done_o <= ~owner;
            req1_done_o <= owner;
            req0_err_o  <= ~owner & ~match;
            req1_err_o  <= owner & ~match;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          req0_done_o <= 1'b0;
          req1_done_o <= 1'b0;
          req0_err_o  <= 1'b0;
          req1_err_o  <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usbf_csr_arb.sv
// Directed bench for usbf_csr_arb: writes, reads, round-robin, timeout, stray pulses, mid-access reset.
module tb_usbf_csr_arb;

  logic        hclk_i = 1'b0;
  logic        hrstn_i;
  logic        req0_valid_i, req0_ready_o, req0_write_i, req0_done_o, req0_err_o;
  logic [31:0] req0_addr_i, req0_wdata_i;
  logic        req1_valid_i, req1_ready_o, req1_write_i, req1_done_o, req1_err_o;
  logic [31:0] req1_addr_i, req1_wdata_i;
  logic [31:0] rsp_rdata_o, addr_o, wdata_o, rdata_i;
  logic        wt_en_o, rd_en_o, enable_o, wt_ready_i, rd_ready_i;

  int checks = 0;
  int errors = 0;

  usbf_csr_arb #(.TIMEOUT_CYC(8), .CNT_W(16)) dut (
    .hclk_i(hclk_i), .hrstn_i(hrstn_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_write_i(req0_write_i),
    .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i),
    .req0_done_o(req0_done_o), .req0_err_o(req0_err_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_write_i(req1_write_i),
    .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i),
    .req1_done_o(req1_done_o), .req1_err_o(req1_err_o),
    .rsp_rdata_o(rsp_rdata_o), .wt_en_o(wt_en_o), .rd_en_o(rd_en_o), .enable_o(enable_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i),
    .wt_ready_i(wt_ready_i), .rd_ready_i(rd_ready_i)
  );

  always #5 hclk_i = ~hclk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one cycle; completion pulses last exactly one cycle unless re-driven.
  task automatic nxt();
    @(posedge hclk_i);
    #1;
    wt_ready_i = 1'b0;
    rd_ready_i = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int own;
    hrstn_i = 1'b0;
    req0_valid_i = 0; req0_write_i = 0; req0_addr_i = '0; req0_wdata_i = '0;
    req1_valid_i = 0; req1_write_i = 0; req1_addr_i = '0; req1_wdata_i = '0;
    rdata_i = '0; wt_ready_i = 0; rd_ready_i = 0;
    #1;
    chk1("rst_wt_en", wt_en_o, 1'b0);
    chk1("rst_rd_en", rd_en_o, 1'b0);
    chk1("rst_enable", enable_o, 1'b0);
    chk1("rst_done0", req0_done_o, 1'b0);
    chk1("rst_done1", req1_done_o, 1'b0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_wdata", wdata_o, 32'h0);
    chk("rst_rdata", rsp_rdata_o, 32'h0);

    // single write on port 0, with a stray read pulse during WAIT and a stray write pulse in IDLE
    nxt(); hrstn_i = 1'b1;
    nxt();
    req0_valid_i = 1; req0_write_i = 1; req0_addr_i = 32'h1000_0004; req0_wdata_i = 32'hA5A5_0001;
    #1;
    chk1("w_ready0", req0_ready_o, 1'b1);
    chk1("w_ready1", req1_ready_o, 1'b0);
    nxt(); req0_valid_i = 0; #1;
    chk1("w_strobe", wt_en_o, 1'b1);
    chk1("w_no_rd", rd_en_o, 1'b0);
    chk1("w_enable", enable_o, 1'b1);
    chk("w_addr", addr_o, 32'h1000_0004);
    chk("w_wdata", wdata_o, 32'hA5A5_0001);
    nxt(); rd_ready_i = 1; #1;
    chk1("w_strobe_1cyc", wt_en_o, 1'b0);
    nxt(); #1;
    chk1("w_mismatch_ignored", req0_done_o, 1'b0);
    chk1("w_still_enabled", enable_o, 1'b1);
    nxt(); wt_ready_i = 1; #1;
    chk1("w_done_not_early", req0_done_o, 1'b0);
    nxt(); #1;
    chk1("w_done0", req0_done_o, 1'b1);
    chk1("w_err0", req0_err_o, 1'b0);
    chk1("w_done1", req1_done_o, 1'b0);
    chk1("w_enable_off", enable_o, 1'b0);
    nxt(); wt_ready_i = 1; #1;
    chk1("w_done_1cyc", req0_done_o, 1'b0);
    nxt(); #1;
    chk1("idle_pulse_enable", enable_o, 1'b0);
    chk1("idle_pulse_done", req0_done_o, 1'b0);

    // single read on port 1, completion in the first WAIT cycle
    nxt();
    rdata_i = 32'hDEAD_BEEF;
    req1_valid_i = 1; req1_write_i = 0; req1_addr_i = 32'h2000_0008;
    #1;
    chk1("r_ready1", req1_ready_o, 1'b1);
    chk1("r_ready0", req0_ready_o, 1'b0);
    nxt(); req1_valid_i = 0; #1;
    chk1("r_strobe", rd_en_o, 1'b1);
    chk1("r_no_wt", wt_en_o, 1'b0);
    chk("r_addr", addr_o, 32'h2000_0008);
    nxt(); rd_ready_i = 1; #1;
    chk1("r_wait_enable", enable_o, 1'b1);
    nxt(); rdata_i = 32'h0; #1;
    chk1("r_done1", req1_done_o, 1'b1);
    chk1("r_err1", req1_err_o, 1'b0);
    chk1("r_done0", req0_done_o, 1'b0);
    chk("r_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
    nxt(); #1;
    chk1("r_done_1cyc", req1_done_o, 1'b0);
    chk("r_rdata_hold", rsp_rdata_o, 32'hDEAD_BEEF);

    // both requesters valid continuously from reset: grants alternate 0,1,0,1
    hrstn_i = 1'b0;
    nxt(); hrstn_i = 1'b1;
    req0_valid_i = 1; req0_write_i = 1; req0_addr_i = 32'h0000_0100; req0_wdata_i = 32'h0000_0011;
    req1_valid_i = 1; req1_write_i = 0; req1_addr_i = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      own = i % 2;
      if (i > 0) nxt();
      #1;
      chk1("rr_ready0", req0_ready_o, own == 0);
      chk1("rr_ready1", req1_ready_o, own == 1);
      nxt(); #1;
      chk1("rr_wt_en", wt_en_o, own == 0);
      chk1("rr_rd_en", rd_en_o, own == 1);
      chk("rr_addr", addr_o, (own == 1) ? 32'h0000_0200 : 32'h0000_0100);
      nxt();
      rdata_i = 32'hC0DE_0000 + i;
      if (own == 0) wt_ready_i = 1; else rd_ready_i = 1;
      #1;
      chk1("rr_no_strobe_wait", wt_en_o | rd_en_o, 1'b0);
      nxt(); #1;
      chk1("rr_done0", req0_done_o, own == 0);
      chk1("rr_done1", req1_done_o, own == 1);
      if (own == 1) chk("rr_rdata", rsp_rdata_o, 32'hC0DE_0000 + i);
    end
    nxt(); req0_valid_i = 0; req1_valid_i = 0; #1;
    chk1("rr_idle_ready0", req0_ready_o, 1'b0);

    // timeout on a port-0 read: done/err at accept+10, read data untouched
    nxt(); req0_valid_i = 1; req0_write_i = 0; req0_addr_i = 32'h0000_0300; #1;
    chk1("to_ready0", req0_ready_o, 1'b1);
    nxt(); req0_valid_i = 0; #1;
    chk1("to_strobe", rd_en_o, 1'b1);
    for (int k = 2; k <= 9; k++) begin
      nxt(); #1;
      chk1("to_no_done", req0_done_o, 1'b0);
    end
    nxt(); #1;
    chk1("to_done0", req0_done_o, 1'b1);
    chk1("to_err0", req0_err_o, 1'b1);
    chk("to_rdata_kept", rsp_rdata_o, 32'hC0DE_0003);
    nxt(); #1;
    chk1("to_err_1cyc", req0_err_o, 1'b0);

    // completion pulse on the last allowed WAIT cycle wins over the timeout
    nxt(); req1_valid_i = 1; req1_write_i = 1; req1_addr_i = 32'h0000_0400; req1_wdata_i = 32'h44; #1;
    chk1("edge_ready1", req1_ready_o, 1'b1);
    nxt(); req1_valid_i = 0; #1;
    chk1("edge_strobe", wt_en_o, 1'b1);
    for (int k = 2; k <= 9; k++) begin
      nxt();
      if (k == 9) wt_ready_i = 1;
      #1;
      chk1("edge_no_done", req1_done_o, 1'b0);
    end
    nxt(); #1;
    chk1("edge_done1", req1_done_o, 1'b1);
    chk1("edge_err1", req1_err_o, 1'b0);

    // reset during WAIT: outputs clear immediately, no done, port 0 preferred after release
    nxt(); nxt();
    req0_valid_i = 1; req0_write_i = 1; req0_addr_i = 32'h0000_0500; req0_wdata_i = 32'h55; #1;
    chk1("mr_ready0", req0_ready_o, 1'b1);
    nxt(); req0_valid_i = 0;
    nxt(); #1;
    chk1("mr_enable_wait", enable_o, 1'b1);
    nxt(); hrstn_i = 1'b0; req0_valid_i = 1; req1_valid_i = 1; #1;
    chk1("mr_enable", enable_o, 1'b0);
    chk1("mr_wt_en", wt_en_o, 1'b0);
    chk("mr_addr", addr_o, 32'h0);
    chk("mr_wdata", wdata_o, 32'h0);
    chk("mr_rdata", rsp_rdata_o, 32'h0);
    chk1("mr_ready0_rst", req0_ready_o, 1'b0);
    chk1("mr_ready1_rst", req1_ready_o, 1'b0);
    nxt(); #1;
    chk1("mr_no_done", req0_done_o, 1'b0);
    hrstn_i = 1'b1; #1;
    chk1("mr_ready0_after", req0_ready_o, 1'b1);
    chk1("mr_ready1_after", req1_ready_o, 1'b0);
    nxt(); req0_valid_i = 0; req1_valid_i = 0;
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
